// File: rtl/serial_cfg_master.sv
// Serial configuration master: pulses an active-low reset downstream, shifts a
// config word out MSB first on o_sclk/o_sdin, then waits for i_ready or times out.
module serial_cfg_master #(
   parameter int NBITS       = 5,
   parameter int HALF_PERIOD = 4,
   parameter int TIMEOUT     = 1023
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_cfg_valid,
   output logic             o_cfg_ready,
   input  logic [NBITS-1:0] i_cfg_data,
   input  logic             i_ready,
   output logic             o_resetbALL,
   output logic             o_sclk,
   output logic             o_sdin,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_timeout
);

   typedef enum logic [2:0] {
      S_IDLE, S_RST, S_PRE, S_SHIFT_LO, S_SHIFT_HI, S_WAIT_RDY, S_DONE, S_ERR
   } state_t;

   localparam logic [7:0]  HP_LAST  = 8'(HALF_PERIOD - 1);
   localparam logic [4:0]  BIT_LAST = 5'(NBITS - 1);
   localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);

   state_t           r_state;
   logic [NBITS-1:0] r_shift;
   logic [7:0]       r_phase_cnt;
   logic [4:0]       r_bit_cnt;
   logic [15:0]      r_wait_cnt;
   logic             r_rdy_q;
   logic             r_cfg_ready;
   logic             r_resetb;
   logic             r_sclk;
   logic             r_sdin;
   logic             r_busy;
   logic             r_done;
   logic             r_timeout;
   logic [NBITS-1:0] w_shift_next;

   assign w_shift_next = r_shift << 1;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_shift     <= '0;
         r_phase_cnt <= '0;
         r_bit_cnt   <= '0;
         r_wait_cnt  <= '0;
         r_rdy_q     <= 1'b0;
         r_cfg_ready <= 1'b0;
         r_resetb    <= 1'b0;
         r_sclk      <= 1'b0;
         r_sdin      <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         r_done  <= 1'b0;
         // Ready is only meaningful while waiting; a stale high from earlier states is dropped.
         r_rdy_q <= (r_state == S_WAIT_RDY) ? i_ready : 1'b0;
         case (r_state)
            S_IDLE: begin
               r_cfg_ready <= 1'b1;
               r_sclk      <= 1'b0;
               r_sdin      <= 1'b0;
               r_busy      <= 1'b0;
               if (i_cfg_valid && r_cfg_ready) begin
                  r_shift     <= i_cfg_data;
                  r_timeout   <= 1'b0;
                  r_cfg_ready <= 1'b0;
                  r_busy      <= 1'b1;
                  r_resetb    <= 1'b0;
                  r_phase_cnt <= '0;
                  r_bit_cnt   <= '0;
                  r_state     <= S_RST;
               end
            end
            S_RST: begin
               if (r_phase_cnt == 8'd1) begin
                  r_phase_cnt <= '0;
                  r_resetb    <= 1'b1;
                  r_sdin      <= r_shift[NBITS-1];
                  r_state     <= S_PRE;
               end else begin
                  r_phase_cnt <= r_phase_cnt + 8'd1;
               end
            end
            S_PRE: begin
               if (r_phase_cnt == 8'd1) begin
                  r_phase_cnt <= '0;
                  r_state     <= S_SHIFT_LO;
               end else begin
                  r_phase_cnt <= r_phase_cnt + 8'd1;
               end
            end
            S_SHIFT_LO: begin
               if (r_phase_cnt == HP_LAST) begin
                  r_phase_cnt <= '0;
                  r_sclk      <= 1'b1;
                  r_state     <= S_SHIFT_HI;
               end else begin
                  r_phase_cnt <= r_phase_cnt + 8'd1;
               end
            end
            S_SHIFT_HI: begin
               if (r_phase_cnt == HP_LAST) begin
                  r_phase_cnt <= '0;
                  r_sclk      <= 1'b0;
                  if (r_bit_cnt == BIT_LAST) begin
                     r_bit_cnt  <= '0;
                     r_sdin     <= 1'b0;
                     r_wait_cnt <= '0;
                     r_state    <= S_WAIT_RDY;
                  end else begin
                     // Next bit is presented on the falling edge so it is settled before the next rise.
                     r_bit_cnt <= r_bit_cnt + 5'd1;
                     r_shift   <= w_shift_next;
                     r_sdin    <= w_shift_next[NBITS-1];
                     r_state   <= S_SHIFT_LO;
                  end
               end else begin
                  r_phase_cnt <= r_phase_cnt + 8'd1;
               end
            end
            S_WAIT_RDY: begin
               if (r_rdy_q) begin
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else if (r_wait_cnt == TO_LAST) begin
                  r_timeout <= 1'b1;
                  r_state   <= S_ERR;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 16'd1;
               end
            end
            S_DONE, S_ERR: begin
               r_wait_cnt  <= '0;
               r_cfg_ready <= 1'b1;
               r_busy      <= 1'b0;
               r_state     <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_cfg_ready = r_cfg_ready;
   assign o_resetbALL = r_resetb;
   assign o_sclk      = r_sclk;
   assign o_sdin      = r_sdin;
   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_serial_cfg_master.sv
// Bench for serial_cfg_master: scoreboard of expected sclk-rise samples and done
// pulses, plus a minimal NBITS=1/HALF_PERIOD=1 instance for the boundary case.
module tb_serial_cfg_master;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       cfg_valid = 1'b0;
   logic [4:0] cfg_data = '0;
   logic       rdy = 1'b0;
   logic       cfg_ready, resetb, sclk, sdin, busy, done, tmo;

   logic       m_valid = 1'b0;
   logic [0:0] m_data = '0;
   logic       m_rdy = 1'b0;
   logic       m_cfg_ready, m_resetb, m_sclk, m_sdin, m_busy, m_done, m_tmo;

   int cyc = 0;
   int n_checks = 0;
   int n_pass = 0;

   typedef struct {
      int   c;
      logic b;
   } sclk_exp_t;

   sclk_exp_t exp_q[$];
   int        done_q[$];
   logic      prev_sclk = 1'b0;
   logic      prev_sdin = 1'b0;

   serial_cfg_master u_dut (
      .i_clk(clk), .i_rst(rst), .i_cfg_valid(cfg_valid), .o_cfg_ready(cfg_ready),
      .i_cfg_data(cfg_data), .i_ready(rdy), .o_resetbALL(resetb), .o_sclk(sclk),
      .o_sdin(sdin), .o_busy(busy), .o_done(done), .o_timeout(tmo)
   );

   serial_cfg_master #(.NBITS(1), .HALF_PERIOD(1), .TIMEOUT(4)) u_dut_min (
      .i_clk(clk), .i_rst(rst), .i_cfg_valid(m_valid), .o_cfg_ready(m_cfg_ready),
      .i_cfg_data(m_data), .i_ready(m_rdy), .o_resetbALL(m_resetb), .o_sclk(m_sclk),
      .o_sdin(m_sdin), .o_busy(m_busy), .o_done(m_done), .o_timeout(m_tmo)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard side: every sclk rise and done pulse must match a queued expectation.
   always @(negedge clk) begin
      if (sclk && !prev_sclk) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL sclk_unexpected: rise at cycle %0d, required none", cyc);
         end else begin
            sclk_exp_t e;
            e = exp_q.pop_front();
            if (cyc !== e.c || sdin !== e.b)
               $display("FAIL sclk_rise: cycle %0d sdin %b, required cycle %0d sdin %b", cyc, sdin, e.c, e.b);
            else
               n_pass++;
         end
      end
      if (sclk && prev_sclk) begin
         n_checks++;
         if (sdin !== prev_sdin)
            $display("FAIL sdin_stable: sdin %b at cycle %0d, required %b", sdin, cyc, prev_sdin);
         else
            n_pass++;
      end
      if (done) begin
         n_checks++;
         if (done_q.size() == 0) begin
            $display("FAIL done_unexpected: o_done at cycle %0d, required none", cyc);
         end else begin
            int dc;
            dc = done_q.pop_front();
            if (cyc !== dc)
               $display("FAIL done_cycle: cycle %0d, required %0d", cyc, dc);
            else
               n_pass++;
         end
      end
      prev_sclk <= sclk;
      prev_sdin <= sdin;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step_to(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic push_bits(input int a, input logic [4:0] w);
      for (int k = 0; k < 5; k++) begin
         sclk_exp_t e;
         e.c = a + 9 + 8 * k;
         e.b = w[4-k];
         exp_q.push_back(e);
      end
   endtask

   task automatic accept(input logic [4:0] w, input bit hold, output int a);
      int n;
      n = 0;
      @(negedge clk);
      while (!cfg_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (cfg_ready !== 1'b1) $display("FAIL accept_ready: o_cfg_ready %b, required 1", cfg_ready);
      else n_pass++;
      cfg_valid = 1'b1;
      cfg_data  = w;
      a = cyc;
      @(negedge clk);
      if (!hold) cfg_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++; if (resetb !== 1'b0)    $display("FAIL rst_resetb: %b, required 0", resetb); else n_pass++;
      n_checks++; if (sclk !== 1'b0)      $display("FAIL rst_sclk: %b, required 0", sclk); else n_pass++;
      n_checks++; if (sdin !== 1'b0)      $display("FAIL rst_sdin: %b, required 0", sdin); else n_pass++;
      n_checks++; if (busy !== 1'b0)      $display("FAIL rst_busy: %b, required 0", busy); else n_pass++;
      n_checks++; if (done !== 1'b0)      $display("FAIL rst_done: %b, required 0", done); else n_pass++;
      n_checks++; if (tmo !== 1'b0)       $display("FAIL rst_timeout: %b, required 0", tmo); else n_pass++;
      n_checks++; if (cfg_ready !== 1'b0) $display("FAIL rst_cfg_ready: %b, required 0", cfg_ready); else n_pass++;
      rst = 1'b0;
      @(negedge clk);
      n_checks++; if (cfg_ready !== 1'b1)   $display("FAIL post_rst_ready: %b, required 1", cfg_ready); else n_pass++;
      n_checks++; if (m_cfg_ready !== 1'b1) $display("FAIL post_rst_ready_min: %b, required 1", m_cfg_ready); else n_pass++;
      $display("reset: outputs cleared, ready after release");
   endtask

   task automatic test_basic;
      int a;
      rdy = 1'b0;
      accept(5'b10110, 1'b0, a);
      push_bits(a, 5'b10110);
      done_q.push_back(a + 52);
      n_checks++; if (resetb !== 1'b0)    $display("FAIL basic_resetb_a1: %b, required 0", resetb); else n_pass++;
      n_checks++; if (cfg_ready !== 1'b0) $display("FAIL basic_ready_a1: %b, required 0", cfg_ready); else n_pass++;
      n_checks++; if (busy !== 1'b1)      $display("FAIL basic_busy_a1: %b, required 1", busy); else n_pass++;
      step_to(a + 2);
      n_checks++; if (resetb !== 1'b0)    $display("FAIL basic_resetb_a2: %b, required 0", resetb); else n_pass++;
      step_to(a + 3);
      n_checks++; if (resetb !== 1'b1)    $display("FAIL basic_resetb_a3: %b, required 1", resetb); else n_pass++;
      n_checks++; if (sdin !== 1'b1)      $display("FAIL basic_pre_sdin: %b, required 1", sdin); else n_pass++;
      step_to(a + 50);
      rdy = 1'b1;
      step_to(a + 52);
      n_checks++; if (busy !== 1'b1)      $display("FAIL basic_busy_done: %b, required 1", busy); else n_pass++;
      step_to(a + 53);
      n_checks++; if (cfg_ready !== 1'b1) $display("FAIL basic_ready_a53: %b, required 1", cfg_ready); else n_pass++;
      n_checks++; if (busy !== 1'b0)      $display("FAIL basic_busy_a53: %b, required 0", busy); else n_pass++;
      n_checks++; if (resetb !== 1'b1)    $display("FAIL basic_resetb_hold: %b, required 1", resetb); else n_pass++;
      rdy = 1'b0;
      $display("basic: word 10110 accepted at cycle %0d", a);
   endtask

   task automatic test_timeout;
      int a, a2, n;
      rdy = 1'b0;
      accept(5'b01101, 1'b0, a);
      push_bits(a, 5'b01101);
      n = 0;
      while (!tmo && n < 1200) begin
         @(negedge clk);
         n++;
      end
      n_checks++; if (cyc !== a + 1068) $display("FAIL timeout_cycle: %0d, required %0d", cyc, a + 1068); else n_pass++;
      n_checks++; if (busy !== 1'b1)    $display("FAIL timeout_busy: %b, required 1", busy); else n_pass++;
      @(negedge clk);
      n_checks++; if (cfg_ready !== 1'b1) $display("FAIL timeout_ready: %b, required 1", cfg_ready); else n_pass++;
      repeat (5) @(negedge clk);
      n_checks++; if (tmo !== 1'b1)     $display("FAIL timeout_sticky: %b, required 1", tmo); else n_pass++;
      // Ready held high from before WAIT_RDY: DONE two cycles after entry.
      rdy = 1'b1;
      accept(5'b11001, 1'b0, a2);
      push_bits(a2, 5'b11001);
      done_q.push_back(a2 + 47);
      n_checks++; if (tmo !== 1'b0)     $display("FAIL timeout_clear: %b, required 0", tmo); else n_pass++;
      step_to(a2 + 48);
      n_checks++; if (cfg_ready !== 1'b1) $display("FAIL early_ready_idle: %b, required 1", cfg_ready); else n_pass++;
      rdy = 1'b0;
      $display("timeout: flag at cycle %0d, cleared by accept at cycle %0d", a + 1068, a2);
   endtask

   task automatic test_mid_reset;
      int a;
      rdy = 1'b0;
      accept(5'b11111, 1'b0, a);
      for (int k = 0; k < 2; k++) begin
         sclk_exp_t e;
         e.c = a + 9 + 8 * k;
         e.b = 1'b1;
         exp_q.push_back(e);
      end
      step_to(a + 20);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_checks++; if (sclk !== 1'b0)      $display("FAIL midrst_sclk: %b, required 0", sclk); else n_pass++;
      n_checks++; if (resetb !== 1'b0)    $display("FAIL midrst_resetb: %b, required 0", resetb); else n_pass++;
      n_checks++; if (cfg_ready !== 1'b0) $display("FAIL midrst_ready_a21: %b, required 0", cfg_ready); else n_pass++;
      @(negedge clk);
      n_checks++; if (cfg_ready !== 1'b1) $display("FAIL midrst_ready_a22: %b, required 1", cfg_ready); else n_pass++;
      step_to(a + 70);
      n_checks++; if (resetb !== 1'b0)    $display("FAIL midrst_resetb_hold: %b, required 0", resetb); else n_pass++;
      $display("mid_reset: reset at cycle %0d of transfer from %0d", a + 20, a);
   endtask

   task automatic test_back_to_back;
      int a;
      rdy = 1'b1;
      accept(5'b10011, 1'b1, a);
      push_bits(a, 5'b10011);
      done_q.push_back(a + 47);
      step_to(a + 10);
      cfg_data = 5'b01100;
      push_bits(a + 48, 5'b01100);
      done_q.push_back(a + 95);
      n_checks++; if (cfg_ready !== 1'b0) $display("FAIL b2b_ready_busy: %b, required 0", cfg_ready); else n_pass++;
      step_to(a + 48);
      n_checks++; if (cfg_ready !== 1'b1) $display("FAIL b2b_ready_a48: %b, required 1", cfg_ready); else n_pass++;
      step_to(a + 49);
      cfg_valid = 1'b0;
      n_checks++; if (cfg_ready !== 1'b0) $display("FAIL b2b_ready_a49: %b, required 0", cfg_ready); else n_pass++;
      n_checks++; if (busy !== 1'b1)      $display("FAIL b2b_busy_a49: %b, required 1", busy); else n_pass++;
      step_to(a + 96);
      n_checks++; if (cfg_ready !== 1'b1) $display("FAIL b2b_ready_end: %b, required 1", cfg_ready); else n_pass++;
      rdy = 1'b0;
      $display("back_to_back: words 10011 then 01100 from cycle %0d", a);
   endtask

   task automatic test_min;
      int a, n;
      m_rdy = 1'b1;
      n = 0;
      @(negedge clk);
      while (!m_cfg_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      m_valid = 1'b1;
      m_data  = 1'b1;
      a = cyc;
      @(negedge clk);
      m_valid = 1'b0;
      step_to(a + 4);
      n_checks++; if (m_sdin !== 1'b1) $display("FAIL min_pre_sdin: %b, required 1", m_sdin); else n_pass++;
      step_to(a + 5);
      n_checks++; if (m_sclk !== 1'b0) $display("FAIL min_sclk_a5: %b, required 0", m_sclk); else n_pass++;
      step_to(a + 6);
      n_checks++; if (m_sclk !== 1'b1 || m_sdin !== 1'b1)
         $display("FAIL min_sclk_a6: sclk %b sdin %b, required 1 1", m_sclk, m_sdin); else n_pass++;
      step_to(a + 7);
      n_checks++; if (m_sclk !== 1'b0 || m_sdin !== 1'b0)
         $display("FAIL min_wait_a7: sclk %b sdin %b, required 0 0", m_sclk, m_sdin); else n_pass++;
      step_to(a + 8);
      n_checks++; if (m_done !== 1'b0) $display("FAIL min_done_a8: %b, required 0", m_done); else n_pass++;
      step_to(a + 9);
      n_checks++; if (m_done !== 1'b1) $display("FAIL min_done_a9: %b, required 1", m_done); else n_pass++;
      step_to(a + 10);
      n_checks++; if (m_cfg_ready !== 1'b1 || m_done !== 1'b0)
         $display("FAIL min_idle_a10: ready %b done %b, required 1 0", m_cfg_ready, m_done); else n_pass++;
      $display("min: NBITS=1 HALF_PERIOD=1 transfer from cycle %0d", a);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_timeout();
      test_mid_reset();
      test_back_to_back();
      test_min();
      repeat (5) @(negedge clk);
      n_checks++; if (exp_q.size() != 0) $display("FAIL sclk_missing: %0d pending, required 0", exp_q.size()); else n_pass++;
      n_checks++; if (done_q.size() != 0) $display("FAIL done_missing: %0d pending, required 0", done_q.size()); else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
